// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: adds CHUNK bits per clock through a carry flop, with a
// start/busy/done handshake and a result held stable between operations.
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             ovf
);

  localparam int unsigned NChunk = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] opa_q, opb_q, part_q, sum_q;
  logic [IdxW-1:0]  idx_q;
  logic             carry_q, cout_q, ovf_q, done_q, busy_q;

  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] part_next;

  // One chunk of the ripple; part_next is the partial register with this chunk merged in.
  always_comb begin
    chunk_a   = opa_q[int'(idx_q) * CHUNK +: CHUNK];
    chunk_b   = opb_q[int'(idx_q) * CHUNK +: CHUNK];
    chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
    part_next = part_q;
    part_next[int'(idx_q) * CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // Subtraction runs as A + ~B + ~Cin, so Cin behaves as a borrow-in.
            opa_q   <= A;
            opb_q   <= sub ? ~B : B;
            carry_q <= sub ? ~Cin : Cin;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          part_q  <= part_next;
          carry_q <= chunk_sum[CHUNK];
          if (idx_q == LastIdx) begin
            sum_q   <= part_next;
            cout_q  <= chunk_sum[CHUNK];
            ovf_q   <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                       (part_next[WIDTH-1] != opa_q[WIDTH-1]);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: a 16/4 and an 8/8 instance, each shadowed by an
// arithmetic reference model compared on every clock, plus directed literal checks.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        st16 = 0, sub16 = 0, cin16 = 0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  logic        st8 = 0, sub8 = 0, cin8 = 0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  int n_cmp = 0;
  int n_bad = 0;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .sub(sub16), .A(a16), .B(b16), .Cin(cin16),
    .busy(busy16), .done(done16), .Sum(sum16), .Cout(cout16), .ovf(ovf16)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .sub(sub8), .A(a8), .B(b8), .Cin(cin8),
    .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8), .ovf(ovf8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain unsigned/signed integer arithmetic.
  function automatic logic [65:0] ref_op(input int w, input logic s, input logic [63:0] a,
                                         input logic [63:0] b, input logic c);
    longint half, full, ua, ub, sa, sb, ur, sr;
    logic co, ov;
    half = longint'(1) << (w - 1);
    full = 2 * half;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    if (!s) begin
      ur = ua + ub + longint'(c);
      co = (ur >= full);
      sr = sa + sb + longint'(c);
    end else begin
      ur = ua - ub - longint'(c);
      co = (ur >= 0);
      sr = sa - sb - longint'(c);
    end
    if (ur < 0) ur = ur + full;
    if (ur >= full) ur = ur - full;
    ov = (sr >= half) || (sr < -half);
    return {ov, co, 64'(ur)};
  endfunction

  int          m16_cnt, m8_cnt;
  logic        m16_done, m8_done;
  logic [65:0] m16_res, m8_res, p16_res, p8_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m16_cnt <= 0; m16_done <= 0; m16_res <= '0; p16_res <= '0;
    end else begin
      m16_done <= 0;
      if (m16_cnt != 0) begin
        m16_cnt <= m16_cnt - 1;
        if (m16_cnt == 1) begin
          m16_res  <= p16_res;
          m16_done <= 1;
        end
      end else if (st16) begin
        p16_res <= ref_op(16, sub16, 64'(a16), 64'(b16), cin16);
        m16_cnt <= 4;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_cnt <= 0; m8_done <= 0; m8_res <= '0; p8_res <= '0;
    end else begin
      m8_done <= 0;
      if (m8_cnt != 0) begin
        m8_cnt <= m8_cnt - 1;
        if (m8_cnt == 1) begin
          m8_res  <= p8_res;
          m8_done <= 1;
        end
      end else if (st8) begin
        p8_res <= ref_op(8, sub8, 64'(a8), 64'(b8), cin8);
        m8_cnt <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m16 busy", busy16, m16_cnt != 0);
      chk("m16 done", done16, m16_done);
      chk("m16 Sum", sum16, m16_res[15:0]);
      chk("m16 Cout", cout16, m16_res[64]);
      chk("m16 ovf", ovf16, m16_res[65]);
      chk("m8 busy", busy8, m8_cnt != 0);
      chk("m8 done", done8, m8_done);
      chk("m8 Sum", sum8, m8_res[7:0]);
      chk("m8 Cout", cout8, m8_res[64]);
      chk("m8 ovf", ovf8, m8_res[65]);
    end
  end

  task automatic run_op(input bit w8, input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] es, input logic ec, input logic eo,
                        input string nm);
    int busy_n;
    bit got;
    @(negedge clk);
    if (w8) begin
      sub8 = s; a8 = a[7:0]; b8 = b[7:0]; cin8 = c; st8 = 1;
    end else begin
      sub16 = s; a16 = a; b16 = b; cin16 = c; st16 = 1;
    end
    @(negedge clk);
    st8 = 0;
    st16 = 0;
    busy_n = 0;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      if ((w8 ? done8 : done16) === 1'b1) got = 1;
      else begin
        if ((w8 ? busy8 : busy16) === 1'b1) busy_n++;
        @(negedge clk);
      end
    end
    chk({nm, " done seen"}, got, 1);
    chk({nm, " busy cycles"}, busy_n, w8 ? 1 : 4);
    chk({nm, " Sum"}, w8 ? {8'h0, sum8} : sum16, es);
    chk({nm, " Cout"}, w8 ? cout8 : cout16, ec);
    chk({nm, " ovf"}, w8 ? ovf8 : ovf16, eo);
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (got %0d, expected 0)", 1);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 0;
    #2;
    chk("reset busy", busy16, 0);
    chk("reset done", done16, 0);
    chk("reset Sum", sum16, 0);
    chk("reset Cout", cout16, 0);
    chk("reset ovf", ovf16, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    run_op(0, 0, 16'h1234, 16'h0FFF, 0, 16'h2233, 0, 0, "add basic");
    run_op(0, 0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, "add wrap");
    run_op(0, 0, 16'h7FFF, 16'h0000, 1, 16'h8000, 0, 1, "add ovf");
    run_op(0, 1, 16'h0005, 16'h0007, 0, 16'hFFFE, 0, 0, "sub borrow");
    run_op(0, 1, 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 1, "sub ovf");
    run_op(1, 0, 16'h00FF, 16'h00FF, 1, 16'h00FF, 1, 0, "w8 single");

    // start held high: busy-time start ignored, done-cycle start accepted.
    @(negedge clk);
    a16 = 16'h1111; b16 = 16'h2222; sub16 = 0; cin16 = 0; st16 = 1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 5) begin
        chk("hold done1", done16, 1);
        chk("hold Sum1", sum16, 16'h3333);
        a16 = 16'h0100; b16 = 16'h0011; sub16 = 0; cin16 = 0;
      end else if (n == 10) begin
        chk("hold done2", done16, 1);
        chk("hold Sum2", sum16, 16'h0111);
        st16 = 0;
      end else begin
        chk("hold no done", done16, 0);
        if (n > 5) chk("hold Sum stable", sum16, 16'h3333);
        a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom); cin16 = 1'($urandom);
      end
    end

    // Asynchronous reset in the second RUN cycle aborts the operation.
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h0FFF; sub16 = 0; cin16 = 0; st16 = 1;
    @(negedge clk);
    st16 = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort busy", busy16, 0);
    chk("abort done", done16, 0);
    chk("abort Sum", sum16, 0);
    chk("abort Cout", cout16, 0);
    chk("abort ovf", ovf16, 0);
    chk("abort Sum8", sum8, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("abort no done", done16, 0);
    end
    run_op(0, 0, 16'h1234, 16'h0FFF, 0, 16'h2233, 0, 0, "after abort");

    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      st16 = ($urandom_range(0, 2) != 0);
      a16 = pick16(); b16 = pick16(); sub16 = 1'($urandom); cin16 = 1'($urandom);
      st8 = ($urandom_range(0, 2) != 0);
      a8 = pick8(); b8 = pick8(); sub8 = 1'($urandom); cin8 = 1'($urandom);
    end
    @(negedge clk);
    st16 = 0;
    st8 = 0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised, multi-cycle add/subtract unit; successor to the 4-bit combinational ripple-carry adder.
- Processes CHUNK bits per clock, rippling the carry through a carry flop, so wide operands can be added with a short critical path.
- Start/busy/done handshake; results are held stable between operations.
- Sits beside the combinational adders in the arithmetic library as the area/timing-friendly wide option.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle. Must satisfy 1 <= CHUNK <= WIDTH.
- Derived: NCHUNK = WIDTH/CHUNK, the cycles per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0: A+B+Cin; 1: A-B-Cin (Cin acts as borrow-in). Sampled with start.
- A  input  WIDTH  operand A, sampled with start.
- B  input  WIDTH  operand B, sampled with start.
- Cin  input  1  carry/borrow in, sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when Sum/Cout/ovf have been updated.
- Sum  output  WIDTH  result, held until the next done.
- Cout  output  1  raw carry out of the MSB. For sub: 1 means no borrow.
- ovf  output  1  two's-complement signed overflow of the final result.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy=0, done=0, Sum=0, Cout=0, ovf=0; internal operand, partial-sum and carry registers cleared.
  - Reset asserted mid-operation aborts the operation; no done is produced.
- States:
  - IDLE: busy=0. On a rising edge with start=1:
    - latch A into opA;
    - latch opB = sub ? ~B : B;
    - carry = sub ? ~Cin : Cin;
    - idx=0; go to RUN.
  - RUN: busy=1. Each edge:
    - computes opA[idx chunk] + opB[idx chunk] + carry;
    - writes the CHUNK-bit result into the partial register at chunk idx;
    - updates carry with the chunk carry-out;
    - idx++.
  - On the edge processing chunk NCHUNK-1:
    - Sum <= completed partial register; Cout <= final carry;
    - ovf <= (opA[MSB]==opB[MSB]) && (result[MSB]!=opA[MSB]), using the inverted opB for sub;
    - done <= 1; busy <= 0; go to IDLE.
- done is high for exactly one cycle, during which busy=0.
- Latency: start sampled at edge E → done=1 and new Sum valid after edge E+NCHUNK.
- Throughput: back-to-back operation is allowed. start=1 while done=1 is accepted at that edge, so a new operation is accepted every NCHUNK+1 cycles.
- start while busy=1 is ignored; no queuing. Changes on A, B, Cin or sub while busy=1 have no effect.
- Sum, Cout and ovf never change except on the done edge or reset. Partial results are never visible on Sum.
- Arithmetic is modulo 2^WIDTH; the carry beyond the MSB goes only to Cout.
- CHUNK=WIDTH degenerate case: a single RUN cycle; done appears 1 edge after start.
- idx counter width is clog2(NCHUNK), minimum 1 bit. No wrap-around beyond NCHUNK-1.

Test Plan:
- WIDTH=16, CHUNK=4: A=0x1234, B=0x0FFF, Cin=0, sub=0 → after 4 cycles: done pulse, Sum=0x2233, Cout=0, ovf=0; busy high for exactly 4 cycles.
- A=0xFFFF, B=0x0001, Cin=0 → Sum=0x0000, Cout=1, ovf=0. Also A=0x7FFF, B=0x0000, Cin=1 → Sum=0x8000, Cout=0, ovf=1 (carry propagates through all chunks).
- sub=1: A=0x0005, B=0x0007, Cin=0 → Sum=0xFFFE, Cout=0, ovf=0. sub=1: A=0x8000, B=0x0001, Cin=0 → Sum=0x7FFF, Cout=1, ovf=1.
- Hold start=1 throughout with changing operands: a second start while busy is ignored (no extra done); start during the done cycle is accepted and the next done follows 4 cycles later with that cycle's operands. Previous Sum stays stable until the new done.
- Pull rst_n low for one cycle in the 2nd RUN cycle → busy, done, Sum, Cout, ovf all 0 immediately (asynchronous), no done afterwards; a fresh start then completes normally.
- Re-run with WIDTH=8, CHUNK=8: A=0xFF, B=0xFF, Cin=1 → done 1 cycle after start, Sum=0xFF, Cout=1, ovf=0.
